// File: rtl/matmul_pkg.sv
// Shared constants and types for the 3x3 matmul operand feeder.
package matmul_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DIM = 3;
  localparam int NELEM = DIM * DIM;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  typedef logic [1:0] idx_t;
endpackage

// File: rtl/matmul_operand_feeder_if.sv
// Element write bus plus row/col operand stream with valid/ready.
interface matmul_operand_feeder_if #(
  parameter int DW = matmul_pkg::DATA_WIDTH,
  parameter int VW = DW * matmul_pkg::DIM
);
  logic          wr_en;
  logic          wr_sel;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [VW-1:0] row;
  logic [VW-1:0] col;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  wr_en, wr_sel, wr_addr, wr_data,
    input  out_ready,
    output row, col, out_valid
  );

  modport slave (
    output wr_en, wr_sel, wr_addr, wr_data,
    output out_ready,
    input  row, col, out_valid
  );
endinterface

// File: rtl/matmul_operand_store.sv
// Two 9-entry element files (A, B) with write decode and
// combinational row(i)/col(j) vector reads.
module matmul_operand_store
  import matmul_pkg::*;
#(
  parameter int DW = 8,
  parameter int VW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic          i_sel,
  input  logic [3:0]    i_addr,
  input  logic [DW-1:0] i_data,
  input  idx_t          i_ri,
  input  idx_t          i_cj,
  output logic [VW-1:0] o_row,
  output logic [VW-1:0] o_col
);

  logic [DW-1:0] r_a [NELEM];
  logic [DW-1:0] r_b [NELEM];
  logic          w_hit;
  logic [3:0]    w_rb;
  logic [3:0]    w_cb;

  assign w_hit = i_we && (i_addr < 4'(NELEM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NELEM; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else if (w_hit) begin
      if (i_sel) r_b[i_addr] <= i_data;
      else       r_a[i_addr] <= i_data;
    end
  end

  // Counter value 3 never occurs; map it to 0 to keep reads in range.
  always_comb begin
    w_rb = 4'd0;
    w_cb = 4'd0;
    unique case (i_ri)
      2'd1:    w_rb = 4'd3;
      2'd2:    w_rb = 4'd6;
      default: w_rb = 4'd0;
    endcase
    unique case (i_cj)
      2'd1:    w_cb = 4'd1;
      2'd2:    w_cb = 4'd2;
      default: w_cb = 4'd0;
    endcase
  end

  assign o_row = {r_a[w_rb], r_a[w_rb + 4'd1], r_a[w_rb + 4'd2]};
  assign o_col = {r_b[w_cb], r_b[w_cb + 4'd3], r_b[w_cb + 4'd6]};

endmodule

// File: rtl/matmul_operand_feeder.sv
// Operand sequencer for the MAC3 stage: sweeps all (i,j) pairs.
// Optional FEEDER_WR_LOCK_EN drops writes while busy and flags wr_err.
module matmul_operand_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 3,
  parameter int VEC_W      = DATA_WIDTH * DIM
) (
  input  logic clk,
  input  logic reset,
  matmul_operand_feeder_if.master bus,
  input  logic       go,
  output logic       busy,
  output logic       mac_start,
  output logic       res_valid,
  output logic [1:0] res_i,
  output logic [1:0] res_j,
  output logic       done
`ifdef FEEDER_WR_LOCK_EN
  ,
  output logic       wr_err
`endif
);
  import matmul_pkg::state_t;
  import matmul_pkg::idx_t;
  import matmul_pkg::IDLE;
  import matmul_pkg::RUN;
  import matmul_pkg::FLUSH;

  localparam idx_t LAST = idx_t'(DIM - 1);

  state_t r_state, w_state_nxt;
  idx_t   r_i, r_j, w_i_nxt, w_j_nxt;
  logic   r_flush;
  logic   r_v1, r_v2;
  idx_t   r_i1, r_j1, r_i2, r_j2;
  logic   w_acc;
  logic   w_we;

  assign busy          = (r_state != IDLE);
  assign bus.out_valid = (r_state == RUN);
  assign w_acc         = bus.out_valid && bus.out_ready;

`ifdef FEEDER_WR_LOCK_EN
  logic r_wr_err;
  assign w_we   = bus.wr_en && !busy;
  assign wr_err = r_wr_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wr_err <= 1'b0;
    else if (bus.wr_en && busy && (bus.wr_addr < 4'd9))
      r_wr_err <= 1'b1;
  end
`else
  assign w_we = bus.wr_en;
`endif

  matmul_operand_store #(
    .DW (DATA_WIDTH),
    .VW (VEC_W)
  ) u_store (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_we),
    .i_sel  (bus.wr_sel),
    .i_addr (bus.wr_addr),
    .i_data (bus.wr_data),
    .i_ri   (r_i),
    .i_cj   (r_j),
    .o_row  (bus.row),
    .o_col  (bus.col)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    unique case (r_state)
      IDLE: begin
        if (go) begin
          w_state_nxt = RUN;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
        end
      end
      RUN: begin
        if (w_acc) begin
          if (r_j == LAST) begin
            w_j_nxt = '0;
            if (r_i == LAST) begin
              w_i_nxt     = '0;
              w_state_nxt = FLUSH;
            end else begin
              w_i_nxt = r_i + 2'd1;
            end
          end else begin
            w_j_nxt = r_j + 2'd1;
          end
        end
      end
      FLUSH: begin
        if (r_flush) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_flush <= (r_state == FLUSH) ? !r_flush : 1'b0;
    end
  end

  // Stage 1 lines up with the MAC input flops, stage 2 with its result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1 <= 1'b0;
      r_i1 <= '0;
      r_j1 <= '0;
      r_v2 <= 1'b0;
      r_i2 <= '0;
      r_j2 <= '0;
    end else begin
      r_v1 <= w_acc;
      r_i1 <= r_i;
      r_j1 <= r_j;
      r_v2 <= r_v1;
      r_i2 <= r_i1;
      r_j2 <= r_j1;
    end
  end

  assign mac_start = r_v1;
  assign res_valid = r_v2;
  assign res_i     = r_i2;
  assign res_j     = r_j2;
  assign done      = (r_state == FLUSH) && r_flush && r_v2;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Directed bench for matmul_operand_feeder: sweeps, stalls,
// go-while-busy, write lock / out-of-range writes, mid-sweep reset.
module tb_matmul_operand_feeder;

  logic       clk;
  logic       reset;
  logic       go;
  logic       busy;
  logic       mac_start;
  logic       res_valid;
  logic [1:0] res_i;
  logic [1:0] res_j;
  logic       done;
`ifdef FEEDER_WR_LOCK_EN
  logic       wr_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [23:0] rows_e [3];
  logic [23:0] cols_e [3];

  matmul_operand_feeder_if bus ();

  matmul_operand_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .go        (go),
    .busy      (busy),
    .mac_start (mac_start),
    .res_valid (res_valid),
    .res_i     (res_i),
    .res_j     (res_j),
    .done      (done)
`ifdef FEEDER_WR_LOCK_EN
    ,
    .wr_err    (wr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [3:0] a,
                    input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic load_mats();
    for (int k = 0; k < 9; k++)
      wr(1'b0, 4'(k), (k == 0 || k == 4 || k == 8) ? 8'd1 : 8'd0);
    for (int k = 0; k < 9; k++)
      wr(1'b1, 4'(k), 8'(k + 1));
  endtask

  // Pair k (accept count) is expected on row/col; accepted pairs
  // flow to mac_start one cycle later and res_valid two cycles later.
  task automatic run_sweep(input string nm, input int st_k,
                           input int st_n, input int go2,
                           input int done_exp);
    int  k, stall, k1, k2, nres, done_cyc, c;
    bit  acc, acc1, acc2, exp_busy, fin;
    k = 0; stall = 0; k1 = 0; k2 = 0; nres = 0;
    done_cyc = -1; acc1 = 0; acc2 = 0; fin = 0;
    bus.out_ready = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    c = 1;
    while (!fin && c < 60) begin
      bus.out_ready = !(k == st_k && stall < st_n);
      if (!bus.out_ready) stall++;
      go = (c == go2);
      exp_busy = (k < 9) || acc1 || acc2;
      chk({nm, "_valid"}, 32'(bus.out_valid), 32'(k < 9));
      chk({nm, "_busy"}, 32'(busy), 32'(exp_busy));
      chk({nm, "_mac"}, 32'(mac_start), 32'(acc1));
      chk({nm, "_res"}, 32'(res_valid), 32'(acc2));
      chk({nm, "_done"}, 32'(done), 32'(acc2 && k2 == 8));
      if (k < 9) begin
        chk({nm, "_row"}, 32'(bus.row), 32'(rows_e[k / 3]));
        chk({nm, "_col"}, 32'(bus.col), 32'(cols_e[k % 3]));
      end
      if (acc2) begin
        chk({nm, "_ri"}, 32'(res_i), 32'(k2 / 3));
        chk({nm, "_rj"}, 32'(res_j), 32'(k2 % 3));
      end
      if (res_valid === 1'b1) nres++;
      if (done === 1'b1) done_cyc = c;
      acc  = (k < 9) && bus.out_ready;
      acc2 = acc1;
      k2   = k1;
      acc1 = acc;
      k1   = k;
      if (acc) k++;
      if (!exp_busy) fin = 1;
      else begin
        tick();
        c++;
      end
    end
    go = 1'b0;
    bus.out_ready = 1'b1;
    chk({nm, "_finished"}, 32'(fin), 32'd1);
    chk({nm, "_done_cyc"}, 32'(done_cyc), 32'(done_exp));
    chk({nm, "_nres"}, 32'(nres), 32'd9);
  endtask

  initial begin
    int n;
    rows_e[0] = 24'h010000;
    rows_e[1] = 24'h000100;
    rows_e[2] = 24'h000001;
    cols_e[0] = 24'h010407;
    cols_e[1] = 24'h020508;
    cols_e[2] = 24'h030609;
    reset = 1'b0;
    go = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_sel = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = 8'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mac", 32'(mac_start), 32'd0);
    chk("rst_res", 32'(res_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_row", 32'(bus.row), 32'd0);
    chk("rst_col", 32'(bus.col), 32'd0);
    chk("rst_resij", 32'({res_i, res_j}), 32'd0);
`ifdef FEEDER_WR_LOCK_EN
    chk("rst_wr_err", 32'(wr_err), 32'd0);
`endif
    reset = 1'b1;
    tick();

    load_mats();
    wr(1'b0, 4'd12, 8'hAA);
    chk("oor_idle_row", 32'(bus.row), 32'h010000);
    chk("oor_idle_col", 32'(bus.col), 32'h010407);
`ifdef FEEDER_WR_LOCK_EN
    chk("oor_idle_err", 32'(wr_err), 32'd0);
`endif

    run_sweep("ident", -1, 0, -1, 11);
    run_sweep("bp", 4, 3, -1, 14);
    run_sweep("gobusy", -1, 0, 5, 11);

    go = 1'b1;
    tick();
    go = 1'b0;
    bus.out_ready = 1'b0;
    wr(1'b0, 4'd12, 8'hAA);
    chk("oor_busy_row", 32'(bus.row), 32'h010000);
`ifdef FEEDER_WR_LOCK_EN
    chk("oor_busy_err", 32'(wr_err), 32'd0);
`endif
    wr(1'b0, 4'd0, 8'hFF);
`ifdef FEEDER_WR_LOCK_EN
    chk("lock_row", 32'(bus.row), 32'h010000);
    chk("lock_err", 32'(wr_err), 32'd1);
`else
    chk("nolock_row", 32'(bus.row), 32'hFF0000);
`endif
    bus.out_ready = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("lock_sweep_end", 32'(busy), 32'd0);
`ifdef FEEDER_WR_LOCK_EN
    chk("lock_err_sticky", 32'(wr_err), 32'd1);
`endif

    load_mats();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_row_pre", 32'(bus.row), 32'h000100);
    chk("mid_res_pre", 32'(res_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_mac", 32'(mac_start), 32'd0);
    chk("mid_res", 32'(res_valid), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_row", 32'(bus.row), 32'd0);
    chk("mid_col", 32'(bus.col), 32'd0);
    chk("mid_resij", 32'({res_i, res_j}), 32'd0);
`ifdef FEEDER_WR_LOCK_EN
    chk("mid_wr_err", 32'(wr_err), 32'd0);
`endif
    reset = 1'b1;
    for (int q = 0; q < 4; q++) begin
      tick();
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_row", 32'(bus.row), 32'd0);
      chk("post_col", 32'(bus.col), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_operand_feeder.md
# matmul_operand_feeder

Upstream operand sequencer for the 3×3 matrix-multiply unit.

- Stores two 3×3 8-bit matrices A and B, written one element at a time.
- On command, presents every (row of A, column of B) pair to the MAC3 dot-product stage in row-major order.
- Drives the MAC's start strobe aligned with the MAC's input flops.
- Emits a result-valid tag pipeline, so a downstream collector knows which C[i][j] the MAC result belongs to.

## Interface

Parameters:
- DATA_WIDTH, 8, element width.
- DIM, 3, matrix dimension. Only 3 is supported; fixed by the 24-bit MAC vectors.
- VEC_W, DATA_WIDTH*DIM, width of the row/col vectors.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low. Assertion clears all state immediately; release is synchronous to clk.
- wr_en  in  1  element write strobe.
- wr_sel  in  1  0 = matrix A, 1 = matrix B.
- wr_addr  in  4  element index, row-major, 0..8. Values 9..15 are ignored (no write).
- wr_data  in  DATA_WIDTH  element value.
- go  in  1  start a 9-pair sweep. Honoured only in IDLE.
- busy  out  1  high in RUN and FLUSH.
- row  out  VEC_W  A[i][0] on [23:16], A[i][1] on [15:8], A[i][2] on [7:0].
- col  out  VEC_W  B[0][j] on [23:16], B[1][j] on [15:8], B[2][j] on [7:0].
- out_valid  out  1  row/col hold a pair.
- out_ready  in  1  downstream accepts the pair this cycle.
- mac_start  out  1  start strobe for MAC3.
- res_valid  out  1  MAC3 result is valid this cycle.
- res_i, res_j  out  2 each  C index of the current result.
- done  out  1  one-cycle pulse when the last result is valid.
- wr_err  out  1  sticky write-while-busy flag. Exists only with the lock feature; see Configuration.

## Operation

State machine:
- IDLE: go → RUN with i=0, j=0.
- RUN: out_valid=1. On out_valid & out_ready:
  - j advances; when j=2, j wraps to 0 and i increments.
  - The accept at (2,2) → FLUSH.
- FLUSH: lasts 2 cycles, draining the tag pipeline → IDLE.
- No explicit DONE state. done is generated in FLUSH, coinciding with the final res_valid.

Stall rule:
- While out_valid & !out_ready, row, col, i and j are held stable.
- Back-pressure may occur on any pair, for any number of cycles.

Writes:
- Accepted in every state unless locked (see Configuration).
- A write in the same cycle as go is applied before the first pair is read.
- Storage is combinationally indexed: row/col reflect the current storage contents.

Other events:
- go while busy: ignored.
- wr_en with wr_addr ≥ 9: ignored, and does not set wr_err.
- Reset mid-sweep: state → IDLE, counters to 0, tag pipeline cleared, storage cleared to 0, no done pulse.

Reset values:
- row, col: 0.
- busy, out_valid, mac_start, res_valid, done, wr_err: 0.
- res_i, res_j: 0.

## Timing

- Accept at cycle c (out_valid & out_ready) → mac_start=1 in cycle c+1, while MAC3's input flops hold the pair.
- res_valid=1 in cycle c+2, with res_i/res_j equal to the (i,j) accepted at c.
- Tag pipeline is 2 stages.
- With out_ready held high: go at cycle 0 → pairs at cycles 1..9, results at cycles 3..11, done at cycle 11, busy falls at cycle 12.
- A stall inserts no mac_start and no res_valid for that cycle.
- Arithmetic is not performed here. All data passes through unmodified; only the counters are 2 bits, wrapping at 3.

## Configuration

- FEEDER_WR_LOCK_EN defined:
  - wr_en while busy is dropped; storage is unchanged.
  - wr_err is set and stays set until reset.
- FEEDER_WR_LOCK_EN undefined:
  - Writes while busy take effect immediately and may alter pairs not yet presented.
  - wr_err is not present.

## Structure

Shared package matmul_pkg:
- DATA_WIDTH and DIM constants.
- State enum: IDLE, RUN, FLUSH.
- 2-bit index typedef.

Sub-module matmul_operand_store:
- Holds the two 9-entry register files and the write decode.
- Exposes a combinational row(i) / col(j) vector read.
- The top level holds the FSM, the counters and the tag pipeline.

## Test plan

- **Identity times B, out_ready=1.** Load A=I and B=1..9 (row-major), pulse go. Required response:
  - First pair: row=0x010000, col=0x010407.
  - res_valid in cycles 3..11 with indices (0,0)…(2,2).
  - done at cycle 11.
- **Back-pressure.** Drop out_ready for 3 cycles at pair (1,1). Required response:
  - row/col stable during the stall.
  - No mac_start during the stall.
  - done delayed by exactly 3 cycles.
- **go while busy.** Pulse go at cycle 5. Required response: ignored; still exactly 9 res_valid pulses.
- **Reset mid-sweep.** Assert reset at pair (1,0). Required response:
  - All outputs 0 immediately.
  - Storage reads 0.
  - No done pulse.
- **Write lock.** With FEEDER_WR_LOCK_EN, write A[0] = 0xFF while busy. Required response: wr_err=1 and A[0] unchanged. Without the macro, the new value appears on row at i=0.
- **Out-of-range write.** wr_addr=12 with wr_data=0xAA. Required response: no storage change; wr_err stays 0.
